// File: rtl/id_ex_hazard_pkg.sv
// id_ex_hazard_pkg
//   Shared constants and types for the miniRV ID/EX pipeline register.
//   - Writeback-source encodings (WB_*), RF write-enable and operand-use levels.
//   - BUBBLE_* zero constants: the field values of an empty (NOP) EX slot.
//   - ex_bundle_t: the control/data bundle held by the ID/EX register.
//   - reg_hit(): one operand's register-dependency compare against the EX destination.
package id_ex_hazard_pkg;

    // Writeback source select (rf_wsel)
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_DREM = 2'd1;   // data-memory read (load)
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_EXT  = 2'd3;

    localparam logic RF_DISABLE = 1'b0;
    localparam logic RF_ENABLE  = 1'b1;
    localparam logic READ       = 1'b1;

    // A bubble is an all-zero bundle: no RF write, no DRAM write, no branch.
    localparam logic [31:0] BUBBLE_PC       = 32'd0;
    localparam logic [31:0] BUBBLE_DATA     = 32'd0;
    localparam logic [4:0]  BUBBLE_WR       = 5'd0;
    localparam logic [2:0]  BUBBLE_BRANCH   = 3'd0;
    localparam logic        BUBBLE_RF_WE    = RF_DISABLE;
    localparam logic [1:0]  BUBBLE_RF_WSEL  = 2'd0;
    localparam logic [3:0]  BUBBLE_ALU_OP   = 4'd0;
    localparam logic        BUBBLE_ALUB_SEL = 1'b0;
    localparam logic        BUBBLE_RAM_WE   = 1'b0;
    localparam logic        BUBBLE_HAVE     = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext;
        logic [4:0]  wr;
        logic [2:0]  branch;
        logic        rf_we;
        logic [1:0]  rf_wsel;
        logic [3:0]  alu_op;
        logic        alub_sel;
        logic        ram_we;
        logic        have_inst;
    } ex_bundle_t;

    localparam ex_bundle_t BUBBLE = '{
        pc:        BUBBLE_PC,
        rd1:       BUBBLE_DATA,
        rd2:       BUBBLE_DATA,
        ext:       BUBBLE_DATA,
        wr:        BUBBLE_WR,
        branch:    BUBBLE_BRANCH,
        rf_we:     BUBBLE_RF_WE,
        rf_wsel:   BUBBLE_RF_WSEL,
        alu_op:    BUBBLE_ALU_OP,
        alub_sel:  BUBBLE_ALUB_SEL,
        ram_we:    BUBBLE_RAM_WE,
        have_inst: BUBBLE_HAVE
    };

    // True when an operand that is actually read matches the EX destination.
    function automatic logic reg_hit(input logic used, input logic [4:0] rs,
                                     input logic [4:0] wr);
        return (used == READ) && (rs == wr);
    endfunction

endpackage

// File: rtl/id_ex_hazard_reg_load_use_detect.sv
// load_use_detect
//   Combinational load-use comparator. Flags when the instruction in EX is a
//   real load writing a non-zero register that the instruction in ID reads.
//   Ports:
//     ex_valid, ex_rf_we, ex_rf_wsel, ex_wr : EX-stage instruction info
//     id_read1, id_read2, id_rs1, id_rs2    : ID-stage operand usage
//     load_use                              : hazard present this cycle
module load_use_detect
    import id_ex_hazard_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_rf_we,
    input  logic [1:0] ex_rf_wsel,
    input  logic [4:0] ex_wr,
    input  logic       id_read1,
    input  logic       id_read2,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       load_use
);

    logic ex_is_load;

    // x0 is never a real destination, so it cannot create a dependency.
    assign ex_is_load = ex_valid && (ex_rf_we == RF_ENABLE) &&
                        (ex_rf_wsel == WB_DREM) && (ex_wr != 5'd0);

    assign load_use = ex_is_load &&
                      (reg_hit(id_read1, id_rs1, ex_wr) ||
                       reg_hit(id_read2, id_rs2, ex_wr));

endmodule

// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg
//   ID/EX pipeline register of the 5-stage miniRV pipeline with load-use
//   hazard detection, branch flush and saturating stall/flush event counters.
//   Ports:
//     clk, rst (async, active high)
//     id_*           : decoder control bundle and ID-stage operands
//     ex_jump        : EX resolved a taken branch / JAL / JALR this cycle
//     ex_*           : registered bundle presented to EX
//     ex_valid       : EX holds a real instruction, not a bubble
//     stall_pc/stall_ifid : hold PC and IF/ID this cycle
//     flush_ifid     : zero IF/ID on the next edge
//     stall_cnt/flush_cnt : saturating event counters
module id_ex_hazard_reg
    import id_ex_hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_rd1,
    input  logic [31:0]      id_rd2,
    input  logic [31:0]      id_ext,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_wr,
    input  logic             id_read1,
    input  logic             id_read2,
    input  logic [2:0]       id_branch,
    input  logic             id_rf_we,
    input  logic [1:0]       id_rf_wsel,
    input  logic [3:0]       id_alu_op,
    input  logic             id_alub_sel,
    input  logic             id_ram_we,
    input  logic             id_have_inst,
    input  logic             ex_jump,
    output logic [31:0]      ex_pc,
    output logic [31:0]      ex_rd1,
    output logic [31:0]      ex_rd2,
    output logic [31:0]      ex_ext,
    output logic [4:0]       ex_wr,
    output logic [2:0]       ex_branch,
    output logic             ex_rf_we,
    output logic [1:0]       ex_rf_wsel,
    output logic [3:0]       ex_alu_op,
    output logic             ex_alub_sel,
    output logic             ex_ram_we,
    output logic             ex_have_inst,
    output logic             ex_valid,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ex_bundle_t ex_q;
    ex_bundle_t id_bundle;
    logic       valid_q;
    logic       load_use;

    assign id_bundle = '{
        pc:        id_pc,
        rd1:       id_rd1,
        rd2:       id_rd2,
        ext:       id_ext,
        wr:        id_wr,
        branch:    id_branch,
        rf_we:     id_rf_we,
        rf_wsel:   id_rf_wsel,
        alu_op:    id_alu_op,
        alub_sel:  id_alub_sel,
        ram_we:    id_ram_we,
        have_inst: id_have_inst
    };

    load_use_detect u_load_use_detect (
        .ex_valid   (valid_q),
        .ex_rf_we   (ex_q.rf_we),
        .ex_rf_wsel (ex_q.rf_wsel),
        .ex_wr      (ex_q.wr),
        .id_read1   (id_read1),
        .id_read2   (id_read2),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .load_use   (load_use)
    );

    // A flush discards the ID instruction anyway, so stalling it is pointless.
    assign stall_pc   = load_use && !ex_jump;
    assign stall_ifid = load_use && !ex_jump;
    assign flush_ifid = ex_jump;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= BUBBLE;
            valid_q   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (ex_jump) begin
            ex_q      <= BUBBLE;
            valid_q   <= 1'b0;
            if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
        end else if (load_use) begin
            // One bubble is enough: next cycle ex_wr belongs to the bubble.
            ex_q      <= BUBBLE;
            valid_q   <= 1'b0;
            if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
        end else begin
            ex_q      <= id_bundle;
            valid_q   <= id_have_inst;
        end
    end

    assign ex_pc        = ex_q.pc;
    assign ex_rd1       = ex_q.rd1;
    assign ex_rd2       = ex_q.rd2;
    assign ex_ext       = ex_q.ext;
    assign ex_wr        = ex_q.wr;
    assign ex_branch    = ex_q.branch;
    assign ex_rf_we     = ex_q.rf_we;
    assign ex_rf_wsel   = ex_q.rf_wsel;
    assign ex_alu_op    = ex_q.alu_op;
    assign ex_alub_sel  = ex_q.alub_sel;
    assign ex_ram_we    = ex_q.ram_we;
    assign ex_have_inst = ex_q.have_inst;
    assign ex_valid     = valid_q;

endmodule
